// File: rtl/text_line_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | text_line_fetch_pkg                                                  |
// | Shared display geometry, glyph codes and fetch FSM state encoding.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package text_line_fetch_pkg;

  localparam int FONTHLEN = 16;  // pixels per glyph, horizontal
  localparam int FONTVLEN = 32;  // scanlines per character row
  localparam int HCHAR    = 48;  // glyphs per row
  localparam int VCHAR    = 18;  // rows per page
  localparam int BITPERCH = 4;   // bits per glyph code
  localparam int ADR_BITS = 10;  // value memory address width

  // Solid block glyph: blank screen after reset and field overflow marker
  localparam logic [3:0] GLYPH_BLOCK = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CONV  = 3'd3,
    ST_WRITE = 3'd4
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/text_line_fetch_bcd_dd_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_dd_iter                                                          |
// | Sequential double-dabble binary-to-BCD converter, one input bit per  |
// | cycle. o_done rises VAL_W-1 cycles after i_start and holds until the |
// | next start. o_ovf flags a carry out of the top digit (value too wide |
// | for DIGITS decimal digits).                                          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module bcd_dd_iter
  import text_line_fetch_pkg::*;
#(
  parameter int VAL_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  i_start,
  input  logic [VAL_W-1:0]      i_value,
  output logic [DIGITS*4-1:0]   o_bcd,
  output logic                  o_ovf,
  output logic                  o_done
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] r_sh;
  logic [BW-1:0]    r_bcd;
  logic             r_ovf;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    w_adj;

  // Add-3 correction for every digit that would reach 10 or more after the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Start loads the value and already shifts in its MSB; remaining bits follow one per cycle
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_sh   <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_bcd  <= {{(BW-1){1'b0}}, i_value[VAL_W-1]};
      r_sh   <= i_value << 1;
      r_ovf  <= 1'b0;
      r_cnt  <= CW'(VAL_W - 1);
      r_done <= (VAL_W == 1);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[BW-2:0], r_sh[VAL_W-1]};
      r_ovf <= r_ovf | w_adj[BW-1];
      r_sh  <= r_sh << 1;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_done <= 1'b1;
      end
    end
  end

  assign o_bcd  = r_bcd;
  assign o_ovf  = r_ovf;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/text_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | text_line_fetch                                                      |
// | Double-buffered text-row builder: on each row request the back row   |
// | becomes the front row, then the next row is fetched from the value   |
// | memory, converted to BCD or hex glyphs and packed into the back row. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module text_line_fetch #(
  parameter int VAL_W    = 10,
  parameter int DIGITS   = 3,
  parameter int BITPERCH = text_line_fetch_pkg::BITPERCH,
  parameter int HCHAR    = text_line_fetch_pkg::HCHAR,
  parameter int VCHAR    = text_line_fetch_pkg::VCHAR,
  parameter int ADR_BITS = text_line_fetch_pkg::ADR_BITS,
  parameter int RD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         line_req,
  input  logic [4:0]                   line_idx,
  input  logic [2:0]                   page,
  input  logic                         hex_mode,
  output logic                         rd_en,
  output logic [ADR_BITS-1:0]          rd_addr,
  input  logic [VAL_W-1:0]             rd_data,
  output logic [HCHAR*BITPERCH-1:0]    line_out,
  output logic                         busy,
  output logic                         overrun
);
  import text_line_fetch_pkg::*;

  localparam int VPL      = HCHAR / DIGITS;
  localparam int LINEBITS = HCHAR * BITPERCH;
  localparam int FW       = DIGITS * BITPERCH;
  localparam int NW       = DIGITS * 4;
  localparam int SPAN     = VCHAR * VPL;
  localparam int CW       = $clog2(RD_LAT + 1);
  localparam int KW       = $clog2(VPL + 1);
  localparam int LBW      = $clog2(LINEBITS);

  fetch_state_t          r_state, w_state_nxt;
  logic [LINEBITS-1:0]   r_front, r_back;
  logic [ADR_BITS-1:0]   r_base, r_rd_addr, w_base;
  logic [KW-1:0]         r_k;
  logic [CW-1:0]         r_cnt;
  logic [VAL_W-1:0]      r_val;
  logic                  r_hex, r_rd_en, r_busy, r_ovr;
  logic [4:0]            w_n;
  logic                  w_conv_start, w_conv_done, w_bcd_ovf, w_hex_ovf, w_blank;
  logic [NW-1:0]         w_bcd, w_hex_nib, w_nib;
  logic [FW-1:0]         w_field;
  logic [LBW-1:0]        w_msb;

  // Base address of the row to prefetch: the one after the displayed row, wrapping at page end
  always_comb begin
    w_n    = (line_idx >= 5'(VCHAR - 1)) ? 5'd0 : line_idx + 5'd1;
    w_base = ADR_BITS'(page) * ADR_BITS'(SPAN) + ADR_BITS'(w_n) * ADR_BITS'(VPL);
  end

  assign w_conv_start = (r_state == ST_WAIT) && (r_cnt == '0) && !r_hex && !line_req;

  bcd_dd_iter #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk     (clk),
    .RST     (RST),
    .i_start (w_conv_start),
    .i_value (rd_data),
    .o_bcd   (w_bcd),
    .o_ovf   (w_bcd_ovf),
    .o_done  (w_conv_done)
  );

  generate
    if (VAL_W > NW) begin : g_hex_wide
      assign w_hex_nib = r_val[NW-1:0];
      assign w_hex_ovf = |r_val[VAL_W-1:NW];
    end else begin : g_hex_narrow
      assign w_hex_nib = NW'(r_val);
      assign w_hex_ovf = 1'b0;
    end
  endgenerate

  assign w_nib   = r_hex ? w_hex_nib : w_bcd;
  assign w_blank = r_hex ? w_hex_ovf : w_bcd_ovf;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_glyph
      assign w_field[gi*BITPERCH +: BITPERCH] =
        w_blank ? BITPERCH'(GLYPH_BLOCK) : BITPERCH'(w_nib[gi*4 +: 4]);
    end
  endgenerate

  // Field k lands at the MSB end of the row, glyph 0 first
  assign w_msb = LBW'(LINEBITS - 1 - int'(r_k) * FW);

  // State register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: a row request always restarts the fill, whatever the current state
  always_comb begin
    w_state_nxt = r_state;
    if (line_req) begin
      w_state_nxt = ST_ISSUE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_ISSUE: w_state_nxt = ST_WAIT;
        ST_WAIT:  if (r_cnt == '0) w_state_nxt = r_hex ? ST_WRITE : ST_CONV;
        ST_CONV:  if (w_conv_done) w_state_nxt = ST_WRITE;
        ST_WRITE: w_state_nxt = (r_k == KW'(VPL - 1)) ? ST_IDLE : ST_ISSUE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: buffer swap, address generation, latency count, data capture and field write
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_front   <= '1;
      r_back    <= '1;
      r_base    <= '0;
      r_rd_addr <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_val     <= '0;
      r_hex     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_rd_en <= (w_state_nxt == ST_ISSUE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_ISSUE) begin
        r_cnt <= CW'(RD_LAT - 1);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (line_req) begin
        r_front   <= r_back;
        r_base    <= w_base;
        r_rd_addr <= w_base;
        r_k       <= '0;
        r_hex     <= hex_mode;
        if (r_state != ST_IDLE) r_ovr <= 1'b1;
      end else begin
        if ((r_state == ST_WAIT) && (r_cnt == '0)) begin
          r_val <= rd_data;
        end
        if (r_state == ST_WRITE) begin
          r_back[w_msb -: FW] <= w_field;
          if (r_k != KW'(VPL - 1)) begin
            r_k       <= r_k + KW'(1);
            r_rd_addr <= r_base + ADR_BITS'(r_k) + ADR_BITS'(1);
          end
        end
      end
    end
  end

  assign rd_en    = r_rd_en;
  assign rd_addr  = r_rd_addr;
  assign line_out = r_front;
  assign busy     = r_busy;
  assign overrun  = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_text_line_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_text_line_fetch                                                   |
// | Directed bench: two instances (read latency 1 and 3) share stimulus  |
// | and a common value memory.                                           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_text_line_fetch;

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         line_req = 1'b0;
  logic [4:0]   line_idx = '0;
  logic [2:0]   page = '0;
  logic         hex_mode = 1'b0;

  logic         rd_en, rd_en3, busy, busy3, overrun, overrun3;
  logic [9:0]   rd_addr, rd_addr3;
  logic [9:0]   rd_data, rd_data3;
  logic [191:0] line_out, line_out3;

  logic [9:0]   mem [0:1023];
  logic [9:0]   r_q3 [0:2];
  logic [191:0] c_ones;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  text_line_fetch dut (
    .clk(clk), .RST(RST), .line_req(line_req), .line_idx(line_idx), .page(page),
    .hex_mode(hex_mode), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .line_out(line_out), .busy(busy), .overrun(overrun)
  );

  text_line_fetch #(.RD_LAT(3)) dut3 (
    .clk(clk), .RST(RST), .line_req(line_req), .line_idx(line_idx), .page(page),
    .hex_mode(hex_mode), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .line_out(line_out3), .busy(busy3), .overrun(overrun3)
  );

  // Memory models: one-cycle and three-cycle registered reads
  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    r_q3[0] <= mem[rd_addr3];
    r_q3[1] <= r_q3[0];
    r_q3[2] <= r_q3[1];
  end
  assign rd_data3 = r_q3[2];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] fld(input logic [191:0] l, input int k);
    logic [191:0] t;
    t = l >> (192 - 12 * (k + 1));
    return t[11:0];
  endfunction

  // Pulse line_req for one cycle; returns at the sample point of the cycle after it
  task automatic pulse_req(input logic [4:0] idx, input logic [2:0] pg, input logic hx);
    @(negedge clk);
    line_req = 1'b1; line_idx = idx; page = pg; hex_mode = hx;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  // Run until both instances are idle; count busy cycles and check rd_addr sequence of dut
  task automatic run_fill(input string tag, input int base, output int b1, output int b3, output int na);
    b1 = 0; b3 = 0; na = 0;
    for (int c = 0; c < 600; c++) begin
      if (busy)  b1++;
      if (busy3) b3++;
      if (rd_en) begin
        check($sformatf("%s rd_addr[%0d]", tag, na), 192'(rd_addr), 192'(base + na));
        na++;
      end
      if (!busy && !busy3) break;
      @(negedge clk);
    end
    check({tag, " reads"}, 192'(na), 192'd16);
  endtask

  initial begin
    int b1, b3, na;
    c_ones = '1;
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    mem[16]  = 10'd123;
    mem[21]  = 10'd1000;
    mem[22]  = 10'd999;
    mem[336] = 10'h2AB;
    mem[337] = 10'h3FF;
    mem[351] = 10'h0AB;
    mem[576] = 10'd456;

    // Reset state
    repeat (3) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    check("rst busy",    192'(busy),    192'd0);
    check("rst rd_en",   192'(rd_en),   192'd0);
    check("rst rd_addr", 192'(rd_addr), 192'd0);
    check("rst overrun", 192'(overrun), 192'd0);
    check("rst line",    line_out,      c_ones);

    // Row 0 requested: prefetch row 1 from addresses 16..31
    pulse_req(5'd0, 3'd0, 1'b0);
    check("req busy",  192'(busy),  192'd1);
    check("req rd_en", 192'(rd_en), 192'd1);
    run_fill("dec", 16, b1, b3, na);
    check("dec cycles lat1", 192'(b1), 192'd208);
    check("dec cycles lat3", 192'(b3), 192'd240);
    check("line stable",     line_out, c_ones);

    // Swap the prefetched row in
    pulse_req(5'd1, 3'd0, 1'b0);
    check("dec f0 123",  192'(fld(line_out, 0)), 192'h123);
    check("dec f1 000",  192'(fld(line_out, 1)), 192'h000);
    check("dec f5 ovf",  192'(fld(line_out, 5)), 192'hFFF);
    check("dec f6 999",  192'(fld(line_out, 6)), 192'h999);
    check("lat3 f0 123", 192'(fld(line_out3, 0)), 192'h123);
    check("lat3 f5 ovf", 192'(fld(line_out3, 5)), 192'hFFF);
    check("lat3 f6 999", 192'(fld(line_out3, 6)), 192'h999);
    run_fill("row2", 32, b1, b3, na);

    // Hex fill of page 1 row 3
    pulse_req(5'd2, 3'd1, 1'b1);
    run_fill("hex", 336, b1, b3, na);
    check("hex cycles lat1", 192'(b1), 192'd48);
    check("hex cycles lat3", 192'(b3), 192'd80);

    // Last row of page 2 wraps to row 0: base 576
    pulse_req(5'd17, 3'd2, 1'b0);
    check("hex f0 2AB",   192'(fld(line_out, 0)), 192'h2AB);
    check("hex f1 3FF",   192'(fld(line_out, 1)), 192'h3FF);
    check("hex f15 0AB",  192'(fld(line_out, 15)), 192'h0AB);
    check("wrap rd_addr", 192'(rd_addr), 192'd576);
    check("no overrun",   192'(overrun), 192'd0);

    // Row request in the middle of the fill
    repeat (49) @(negedge clk);
    pulse_req(5'd3, 3'd0, 1'b0);
    check("ovr flag",     192'(overrun), 192'd1);
    check("ovr f0 456",   192'(fld(line_out, 0)), 192'h456);
    check("ovr f15 old",  192'(fld(line_out, 15)), 192'h0AB);
    check("ovr rd_en",    192'(rd_en), 192'd1);
    run_fill("restart", 64, b1, b3, na);
    check("ovr sticky",   192'(overrun), 192'd1);

    // Reset in the middle of a fill
    pulse_req(5'd5, 3'd0, 1'b0);
    repeat (20) @(negedge clk);
    RST = 1'b1;
    #1;
    check("arst busy",    192'(busy),    192'd0);
    check("arst rd_en",   192'(rd_en),   192'd0);
    check("arst overrun", 192'(overrun), 192'd0);
    check("arst line",    line_out,      c_ones);
    @(negedge clk);
    RST = 1'b0;
    na = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rd_en || rd_en3) na++;
    end
    check("no read after rst", 192'(na), 192'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
